// File: rtl/prescaler_if.sv
// Speed-select / tick bundle between the user speed inputs and the prescaler.
// The tick is a one-cycle strobe with no back-pressure: the consumer must act on it in that cycle.
interface prescaler_if;
   logic [3:0] speed_i;
   logic       tick_o;

   modport master (
      output speed_i,
      input  tick_o
   );

   modport slave (
      input  speed_i,
      output tick_o
   );
endinterface

// File: rtl/prescaler.sv
// Divides clk_i into a periodic one-cycle tick; the period in cycles is chosen by a 4-bit speed code.
// Rates are 0.5/1/2/4/8 Hz relative to CLK_HZ. Reset is synchronous and active-high.
module prescaler #(
   parameter int CLK_HZ = 50_000_000,
   parameter int CNT_W  = 27
) (
   input  logic        clk_i,
   input  logic        rst_i,
   prescaler_if.slave  bus
);

   // Limits are widened before scaling so 2*CLK_HZ cannot overflow a 32-bit int.
   localparam longint     CLK_L     = longint'(CLK_HZ);
   localparam logic [CNT_W-1:0] LIM_0P5 = CNT_W'(CLK_L * 2);
   localparam logic [CNT_W-1:0] LIM_1   = CNT_W'(CLK_L);
   localparam logic [CNT_W-1:0] LIM_2   = CNT_W'(CLK_L / 2);
   localparam logic [CNT_W-1:0] LIM_4   = CNT_W'(CLK_L / 4);
   localparam logic [CNT_W-1:0] LIM_8   = CNT_W'(CLK_L / 8);

   logic [CNT_W-1:0] limit;
   logic [CNT_W-1:0] limit_m1;
   logic [CNT_W-1:0] cnt;
   logic             tick_q;
   logic             wrap;

   always_comb begin
      limit = LIM_8;
      unique case (bus.speed_i)
         4'b0001: limit = LIM_0P5;
         4'b0011: limit = LIM_1;
         4'b0111: limit = LIM_2;
         4'b1111: limit = LIM_4;
         default: limit = LIM_8;
      endcase
   end

   // Using >= rather than == lets a drop to a shorter period wrap immediately.
   assign limit_m1 = limit - CNT_W'(1);
   assign wrap     = (cnt >= limit_m1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt    <= '0;
         tick_q <= 1'b0;
      end else if (wrap) begin
         cnt    <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt    <= cnt + CNT_W'(1);
         tick_q <= 1'b0;
      end
   end

   assign bus.tick_o = tick_q;

endmodule

// File: tb/tb_prescaler.sv
// Directed bench for prescaler at CLK_HZ=80 (limits 160/80/40/20/10).
// Inputs change and outputs are sampled on the falling edge.
module tb_prescaler;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   prescaler_if bus ();

   prescaler #(
      .CLK_HZ(80),
      .CNT_W (27)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL global_timeout: simulation still running at %0t, required done", $time);
      $fatal(1, "timeout");
   end

   // Driver tasks
   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns the number of rising edges until tick_o is seen high, -1 if the budget expires.
   task automatic edges_to_tick(input int budget, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (bus.tick_o === 1'b1) break;
         if (n >= budget) begin
            n = -1;
            break;
         end
      end
   endtask

   // Scenarios
   task automatic test_reset;
      int n;
      bus.speed_i = 4'b0101;
      apply_reset(5);
      n_cmp++;
      if (bus.tick_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_tick: got %b, required 0", bus.tick_o);
      end
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 10) begin
         n_err++;
         $display("FAIL first_tick_0101: got %0d edges, required 10", n);
      end
      for (int i = 0; i < 3; i++) begin
         edges_to_tick(400, n);
         n_cmp++;
         if (n !== 10) begin
            n_err++;
            $display("FAIL period_0101[%0d]: got %0d edges, required 10", i, n);
         end
      end
   endtask

   task automatic test_speeds;
      logic [3:0] codes [8];
      int         lims  [8];
      int         n;
      codes = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b1000, 4'b1110, 4'b0010};
      lims  = '{160, 80, 40, 20, 10, 10, 10, 10};
      for (int i = 0; i < 8; i++) begin
         bus.speed_i = codes[i];
         apply_reset(2);
         edges_to_tick(400, n);
         n_cmp++;
         if (n !== lims[i]) begin
            n_err++;
            $display("FAIL first_tick_%b: got %0d edges, required %0d", codes[i], n, lims[i]);
         end
         edges_to_tick(400, n);
         n_cmp++;
         if (n !== lims[i]) begin
            n_err++;
            $display("FAIL period_%b: got %0d edges, required %0d", codes[i], n, lims[i]);
         end
      end
   endtask

   task automatic test_speed_down;
      int n;
      int early;
      bus.speed_i = 4'b0001;
      apply_reset(2);
      early = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.tick_o === 1'b1) early++;
      end
      n_cmp++;
      if (early !== 0) begin
         n_err++;
         $display("FAIL down_no_early_tick: got %0d ticks, required 0", early);
      end
      bus.speed_i = 4'b1111;
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL down_wrap: got %0d edges, required 1", n);
      end
      for (int i = 0; i < 2; i++) begin
         edges_to_tick(400, n);
         n_cmp++;
         if (n !== 20) begin
            n_err++;
            $display("FAIL down_period[%0d]: got %0d edges, required 20", i, n);
         end
      end
      // cnt exactly at the new limit-1 also wraps on the next edge
      bus.speed_i = 4'b0011;
      apply_reset(2);
      repeat (19) @(negedge clk);
      bus.speed_i = 4'b1111;
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL down_equal_wrap: got %0d edges, required 1", n);
      end
   endtask

   task automatic test_speed_up;
      int n;
      bus.speed_i = 4'b1111;
      apply_reset(2);
      repeat (5) @(negedge clk);
      bus.speed_i = 4'b0011;
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 75) begin
         n_err++;
         $display("FAIL up_continue: got %0d edges, required 75", n);
      end
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 80) begin
         n_err++;
         $display("FAIL up_period: got %0d edges, required 80", n);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      bus.speed_i = 4'b0000;
      apply_reset(2);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (bus.tick_o !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_tick: got %b, required 0", bus.tick_o);
      end
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 10) begin
         n_err++;
         $display("FAIL mid_reset_restart: got %0d edges, required 10", n);
      end
      // Reset lands on the edge that would have produced a tick
      apply_reset(1);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (bus.tick_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_on_tick_edge: got %b, required 0", bus.tick_o);
      end
      edges_to_tick(400, n);
      n_cmp++;
      if (n !== 10) begin
         n_err++;
         $display("FAIL reset_on_tick_restart: got %0d edges, required 10", n);
      end
   endtask

   // Scoreboard sequence and final report
   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      bus.speed_i = 4'b0101;
      test_reset();
      test_speeds();
      test_speed_down();
      test_speed_up();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
